hc283_serial_adder: RTL

Parametrised, multi-cycle successor to the 4-bit HC_283 adder. It adds two WIDTH-bit operands one SLICE-bit slice per clock, LSB slice first, and holds the inter-slice carry in a flip-flop, so one 4-bit adder slice is reused across the whole word. A start/busy/done handshake frames each operation. It serves datapaths that need wide addition or subtraction at low area and can tolerate multi-cycle latency.

---
 rtl/hc283_serial_adder.sv | 118 +++++++++++
 1 files changed

// File: rtl/hc283_serial_adder.sv
// Slice-serial adder/subtractor: one SLICE-bit adder reused over WIDTH/SLICE cycles, LSB first.
// Optional macro HC283_SUB_EN enables subtract mode (A + ~B + 1); otherwise Mode is ignored.
module hc283_serial_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             Start,
  input  logic             Mode,
  input  logic             Cin,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] DataOut,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE, RUN} stateType;

  stateType         state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] workSum;
  logic [WIDTH-1:0] nextSum;
  logic [WIDTH-1:0] bLoad;
  logic             carryReg;
  logic             cLoad;
  logic [IW-1:0]    sliceIdx;

  logic [SLICE-1:0] aSlices [N];
  logic [SLICE-1:0] bSlices [N];
  logic [SLICE-1:0] sliceA;
  logic [SLICE-1:0] sliceB;
  logic [SLICE-1:0] sliceSum;
  logic             sliceCout;
  logic             msbCin;

`ifdef HC283_SUB_EN
  // Subtraction is folded into the load: invert B and force the initial carry.
  assign bLoad = Mode ? ~DataIn2 : DataIn2;
  assign cLoad = Mode ? 1'b1 : Cin;
`else
  logic unusedMode;
  assign unusedMode = Mode;
  assign bLoad      = DataIn2;
  assign cLoad      = Cin;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : gSlice
      assign aSlices[gi] = aReg[gi*SLICE +: SLICE];
      assign bSlices[gi] = bReg[gi*SLICE +: SLICE];
      assign nextSum[gi*SLICE +: SLICE] =
        (sliceIdx == IW'(gi)) ? sliceSum : workSum[gi*SLICE +: SLICE];
    end
  endgenerate

  assign sliceA = aSlices[sliceIdx];
  assign sliceB = bSlices[sliceIdx];
  assign {sliceCout, sliceSum} = {1'b0, sliceA} + {1'b0, sliceB} + {{SLICE{1'b0}}, carryReg};

  // Carry into the word MSB, recovered from the top bit of the current slice.
  assign msbCin = sliceA[SLICE-1] ^ sliceB[SLICE-1] ^ sliceSum[SLICE-1];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      aReg     <= '0;
      bReg     <= '0;
      workSum  <= '0;
      carryReg <= 1'b0;
      sliceIdx <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      DataOut  <= '0;
      Cout     <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            aReg     <= DataIn1;
            bReg     <= bLoad;
            carryReg <= cLoad;
            sliceIdx <= '0;
            Busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          workSum  <= nextSum;
          carryReg <= sliceCout;
          if (sliceIdx == LAST_IDX) begin
            DataOut <= nextSum;
            Cout    <= sliceCout;
            Ovf     <= msbCin ^ sliceCout;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            sliceIdx <= sliceIdx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
